// File: rtl/id_hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_hazard_controller: ID-stage forwarding select, load-use stall and |
// | branch flush control, with a saturating stall counter.              |
// | Revision: 1.0                                                       |
// +----------------------------------------------------------------------+

package id_hazard_pkg;
  typedef enum logic [1:0] {
    NO_FWD     = 2'd0,
    EX_ID_FWD  = 2'd1,
    MEM_ID_FWD = 2'd2,
    WB_ID_FWD  = 2'd3
  } ForwardingControl;
endpackage

module id_hazard_controller #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                id_valid,
  input  logic [4:0]                          id_rs1,
  input  logic [4:0]                          id_rs2,
  input  logic                                id_uses_rs1,
  input  logic                                id_uses_rs2,
  input  logic [4:0]                          id_rd,
  input  logic                                id_reg_wr_en,
  input  logic                                id_is_load,
  input  logic                                branch_decision,
  output id_hazard_pkg::ForwardingControl     fwd_reg_file_rd_sel_1,
  output id_hazard_pkg::ForwardingControl     fwd_reg_file_rd_sel_2,
  output logic                                stall,
  output logic                                id_ex_bubble,
  output logic                                flush_if_id,
  output logic [STALL_CNT_W-1:0]              stall_count
);
  import id_hazard_pkg::*;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr_en;
    logic       is_load;
  } shadow_t;

  shadow_t                ex_q, ex_d;
  shadow_t                mem_q, mem_d;
  shadow_t                wb_q, wb_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
  logic                   load_use;
  logic                   w_unused_wb_is_load;

  // x0 is hardwired to zero, so a write to it never produces a value.
  function automatic logic produces(input shadow_t e, input logic [4:0] r);
    return e.valid && e.wr_en && (e.rd == r) && (r != 5'd0);
  endfunction

  function automatic ForwardingControl select_src(
    input logic       uses,
    input logic [4:0] rs,
    input shadow_t    ex,
    input shadow_t    mem,
    input shadow_t    wb
  );
    ForwardingControl sel;
    sel = NO_FWD;
    if (uses && (rs != 5'd0)) begin
      if (produces(ex, rs))       sel = EX_ID_FWD;
      else if (produces(mem, rs)) sel = MEM_ID_FWD;
      else if (produces(wb, rs))  sel = WB_ID_FWD;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_reg_file_rd_sel_1 = select_src(id_uses_rs1, id_rs1, ex_q, mem_q, wb_q);
    fwd_reg_file_rd_sel_2 = select_src(id_uses_rs2, id_rs2, ex_q, mem_q, wb_q);

    // Only a load still in EX cannot be forwarded in time; MEM/WB loads can.
    load_use = id_valid && ex_q.is_load &&
               ((id_uses_rs1 && produces(ex_q, id_rs1)) ||
                (id_uses_rs2 && produces(ex_q, id_rs2)));

    stall        = load_use;
    id_ex_bubble = load_use;
    flush_if_id  = id_valid && branch_decision && !load_use;
    stall_count  = stall_count_q;

    wb_d  = mem_q;
    mem_d = ex_q;
    ex_d  = '0;
    if (!load_use) begin
      ex_d.valid   = id_valid;
      ex_d.rd      = id_rd;
      ex_d.wr_en   = id_reg_wr_en;
      ex_d.is_load = id_is_load;
    end

    stall_count_d = stall_count_q;
    if (load_use && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // The oldest entry's load flag has no consumer beyond WB.
  assign w_unused_wb_is_load = wb_q.is_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_controller.sv
`default_nettype none
// Directed table-driven bench for id_hazard_controller, plus hand sequences
// for counter saturation and asynchronous reset during a stall.
module tb_id_hazard_controller;
  import id_hazard_pkg::*;

  localparam int W   = 4;
  localparam int NO  = 0;
  localparam int EXF = 1;
  localparam int MEF = 2;
  localparam int WBF = 3;

  logic             clk;
  logic             reset_n;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_uses_rs1, id_uses_rs2;
  logic             id_reg_wr_en, id_is_load, branch_decision;
  ForwardingControl sel1, sel2;
  logic             stall, id_ex_bubble, flush_if_id;
  logic [W-1:0]     stall_count;

  int checks   = 0;
  int failures = 0;

  id_hazard_controller #(.STALL_CNT_W(W)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .id_valid              (id_valid),
    .id_rs1                (id_rs1),
    .id_rs2                (id_rs2),
    .id_uses_rs1           (id_uses_rs1),
    .id_uses_rs2           (id_uses_rs2),
    .id_rd                 (id_rd),
    .id_reg_wr_en          (id_reg_wr_en),
    .id_is_load            (id_is_load),
    .branch_decision       (branch_decision),
    .fwd_reg_file_rd_sel_1 (sel1),
    .fwd_reg_file_rd_sel_2 (sel2),
    .stall                 (stall),
    .id_ex_bubble          (id_ex_bubble),
    .flush_if_id           (flush_if_id),
    .stall_count           (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       wr, ld, br;
    int         s1, s2;
    logic       st, fl;
    int         cnt;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic v, input int rs1, input int rs2,
                              input logic u1, input logic u2, input int rd,
                              input logic wr, input logic ld, input logic br,
                              input int s1, input int s2, input logic st,
                              input logic fl, input int cnt);
    vec_t t;
    t.v = v; t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0]; t.u1 = u1; t.u2 = u2;
    t.rd = rd[4:0]; t.wr = wr; t.ld = ld; t.br = br;
    t.s1 = s1; t.s2 = s2; t.st = st; t.fl = fl; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2;
    id_uses_rs1 = t.u1; id_uses_rs2 = t.u2; id_rd = t.rd;
    id_reg_wr_en = t.wr; id_is_load = t.ld; branch_decision = t.br;
  endtask

  task automatic check_row(input string tag, input vec_t t);
    chk({tag, "_sel1"},   int'(sel1), t.s1);
    chk({tag, "_sel2"},   int'(sel2), t.s2);
    chk({tag, "_stall"},  int'(stall), int'(t.st));
    chk({tag, "_bubble"}, int'(id_ex_bubble), int'(t.st));
    chk({tag, "_flush"},  int'(flush_if_id), int'(t.fl));
    chk({tag, "_cnt"},    int'(stall_count), t.cnt);
  endtask

  vec_t lu;
  int   nstall;

  initial begin
    //            v rs1 rs2 u1 u2 rd wr ld br  s1   s2  st fl cnt
    tbl[0]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, NO,  NO,  0, 0, 0);
    tbl[1]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 1, EXF, NO,  0, 1, 0);
    tbl[2]  = mk(1, 5, 6, 1, 1, 0, 0, 0, 0, MEF, EXF, 0, 0, 0);
    tbl[3]  = mk(1, 5, 6, 1, 1, 7, 1, 1, 0, WBF, MEF, 0, 0, 0);
    tbl[4]  = mk(1, 1, 7, 1, 1, 8, 1, 0, 1, NO,  EXF, 1, 0, 0);
    tbl[5]  = mk(1, 1, 7, 1, 1, 8, 1, 0, 1, NO,  MEF, 0, 1, 1);
    tbl[6]  = mk(1, 7, 8, 1, 1, 3, 1, 0, 0, WBF, EXF, 0, 0, 1);
    tbl[7]  = mk(1, 3, 3, 1, 1, 9, 1, 0, 0, EXF, EXF, 0, 0, 1);
    tbl[8]  = mk(1, 3, 8, 0, 1, 3, 1, 0, 0, NO,  WBF, 0, 0, 1);
    tbl[9]  = mk(1, 3, 3, 1, 1, 0, 1, 1, 0, EXF, EXF, 0, 0, 1);
    tbl[10] = mk(1, 0, 0, 1, 1, 0, 1, 0, 0, NO,  NO,  0, 0, 1);
    tbl[11] = mk(1, 0, 0, 1, 1, 0, 1, 0, 0, NO,  NO,  0, 0, 1);
    tbl[12] = mk(1, 0, 0, 1, 1, 4, 1, 1, 0, NO,  NO,  0, 0, 1);
    tbl[13] = mk(0, 4, 0, 1, 0, 0, 0, 0, 1, EXF, NO,  0, 0, 1);
    tbl[14] = mk(1, 4, 0, 1, 0, 0, 0, 0, 0, MEF, NO,  0, 0, 1);

    // Reset state: a valid branching instruction must still flush.
    reset_n = 1'b0;
    drive(mk(1, 5, 5, 1, 1, 5, 1, 1, 1, NO, NO, 0, 1, 0));
    repeat (2) @(negedge clk);
    #1;
    check_row("reset", mk(1, 5, 5, 1, 1, 5, 1, 1, 1, NO, NO, 0, 1, 0));
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check_row($sformatf("row%0d", i), tbl[i]);
    end

    // lw x10 that reads x10 alternates stall / release every cycle.
    lu = mk(1, 10, 0, 1, 0, 10, 1, 1, 0, NO, NO, 0, 0, 0);
    nstall = 0;
    for (int c = 0; c < 100 && nstall < 20; c++) begin
      @(negedge clk);
      drive(lu);
      #1;
      if (stall) nstall++;
    end
    chk("sat_stalls_seen", nstall, 20);
    @(negedge clk);
    #1;
    chk("sat_count", int'(stall_count), 15);

    // One more stall must leave the counter pinned at all-ones.
    nstall = 0;
    for (int c = 0; c < 4 && nstall == 0; c++) begin
      @(negedge clk);
      #1;
      if (stall) nstall = 1;
    end
    chk("hold_stall_seen", nstall, 1);
    @(negedge clk);
    #1;
    chk("sat_hold", int'(stall_count), 15);

    nstall = 0;
    for (int c = 0; c < 4 && nstall == 0; c++) begin
      @(negedge clk);
      #1;
      if (stall) nstall = 1;
    end
    chk("pre_reset_stall", int'(stall), 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_stall",  int'(stall), 0);
    chk("async_rst_bubble", int'(id_ex_bubble), 0);
    chk("async_rst_cnt",    int'(stall_count), 0);
    chk("async_rst_sel1",   int'(sel1), NO);
    @(negedge clk);
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
